// File: rtl/ahb_sram_bridge_bwe.sv
// AHB-lite slave to single-port synchronous SRAM with per-byte write enables from HSIZE/HADDR.
// Latency: reads and writes are zero-wait; SRAM read data is returned in the data-phase cycle.
// Backpressure: one wait state on a write directly followed by a read; two-cycle ERROR on illegal transfers.
module ahb_sram_bridge_bwe #(
    parameter  int ADDR_W = 12,
    parameter  int DATA_W = 32,
    localparam int BE_W   = DATA_W / 8,
    localparam int LSB_W  = $clog2(BE_W),
    localparam int WA_W   = ADDR_W - LSB_W
) (
    input  logic              I_HCLK,
    input  logic              I_HRESET,
    input  logic              I_HSEL,
    input  logic              I_HREADY,
    input  logic [ADDR_W-1:0] I_HADDR,
    input  logic [1:0]        I_HTRANS,
    input  logic              I_HWRITE,
    input  logic [2:0]        I_HSIZE,
    input  logic [DATA_W-1:0] I_HWDATA,
    output logic [DATA_W-1:0] O_HRDATA,
    output logic              O_HREADYOUT,
    output logic              O_HRESP,
    output logic [WA_W-1:0]   O_MADDR,
    output logic [DATA_W-1:0] O_MWDATA,
    output logic              O_MWREN,
    output logic [BE_W-1:0]   O_MBE,
    output logic              O_MREN,
    input  logic [DATA_W-1:0] I_MRDATA
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_STALL,
        ST_ERR1,
        ST_ERR2
    } state_t;

    typedef struct packed {
        logic [WA_W-1:0] addr;
        logic [BE_W-1:0] be;
    } wr_req_t;

    state_t  state;
    wr_req_t wr_q;

    logic [LSB_W-1:0] hoff;
    logic [WA_W-1:0]  hword;
    logic             size_ok;
    logic             align_ok;
    logic             legal;
    logic             vap;
    logic             collide;
    logic             decode;
    logic             unused_trans;

    // Low address bits that must be zero for a transfer of 2^sz bytes.
    function automatic logic [LSB_W-1:0] align_mask(input logic [2:0] sz);
        logic [LSB_W-1:0] m;
        m = '0;
        for (int i = 0; i < LSB_W; i++) begin
            m[i] = (i < int'(sz));
        end
        return m;
    endfunction

    function automatic logic [BE_W-1:0] byte_mask(input logic [2:0] sz, input logic [LSB_W-1:0] off);
        logic [BE_W-1:0] m;
        int lo;
        int n;
        m  = '0;
        lo = int'(off);
        n  = 1 << sz;
        for (int i = 0; i < BE_W; i++) begin
            m[i] = (i >= lo) && (i < lo + n);
        end
        return m;
    endfunction

    assign hoff         = I_HADDR[LSB_W-1:0];
    assign hword        = I_HADDR[ADDR_W-1:LSB_W];
    assign size_ok      = (I_HSIZE <= 3'(LSB_W));
    assign align_ok     = (hoff & align_mask(I_HSIZE)) == '0;
    assign legal        = size_ok & align_ok;
    assign vap          = I_HSEL & I_HREADY & I_HTRANS[1];
    assign unused_trans = I_HTRANS[0];

    // Collision ignores I_HREADY: on the bus it is our own HREADYOUT, so using it would close a loop.
    assign collide = (state == ST_WRITE) & I_HSEL & I_HTRANS[1] & ~I_HWRITE & legal;
    assign decode  = (state != ST_ERR1) & ~collide;

    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET) begin
            state <= ST_IDLE;
            wr_q  <= '0;
        end else if (state == ST_ERR1) begin
            state <= ST_ERR2;
        end else if (collide) begin
            state <= ST_STALL;
        end else if (vap) begin
            if (!legal) begin
                state <= ST_ERR1;
            end else if (I_HWRITE) begin
                state      <= ST_WRITE;
                wr_q.addr  <= hword;
                wr_q.be    <= byte_mask(I_HSIZE, hoff);
            end else begin
                state <= ST_READ;
            end
        end else begin
            state <= ST_IDLE;
        end
    end

    assign O_MWREN     = (state == ST_WRITE);
    assign O_MBE       = O_MWREN ? wr_q.be : '0;
    assign O_MADDR     = O_MWREN ? wr_q.addr : hword;
    assign O_MWDATA    = I_HWDATA;
    // Read strobe is gated by reset so nothing reaches the SRAM while reset is held.
    assign O_MREN      = decode & vap & legal & ~I_HWRITE & ~I_HRESET;
    assign O_HRDATA    = I_MRDATA;
    assign O_HREADYOUT = (state != ST_ERR1) & ~collide;
    assign O_HRESP     = (state == ST_ERR1) | (state == ST_ERR2);

endmodule

// File: tb/tb_ahb_sram_bridge_bwe.sv
// Directed bench for ahb_sram_bridge_bwe: 32-bit and 64-bit builds, each with a behavioural SRAM.
module tb_ahb_sram_bridge_bwe;

    logic        clk;
    logic        rst;
    int          checks;
    int          failures;

    // 32-bit instance
    logic        hsel, hwrite, hready, hreadyout, hresp, mwren, mren;
    logic [11:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] hwdata, hrdata, mwdata, mrdata;
    logic [9:0]  maddr;
    logic [3:0]  mbe;
    logic [31:0] mem32 [0:1023];

    // 64-bit instance
    logic        w_hsel, w_hwrite, w_hready, w_hreadyout, w_hresp, w_mwren, w_mren;
    logic [11:0] w_haddr;
    logic [1:0]  w_htrans;
    logic [2:0]  w_hsize;
    logic [63:0] w_hwdata, w_hrdata, w_mwdata, w_mrdata;
    logic [8:0]  w_maddr;
    logic [7:0]  w_mbe;
    logic [63:0] mem64 [0:511];

    assign hready   = hreadyout;
    assign w_hready = w_hreadyout;

    ahb_sram_bridge_bwe #(.ADDR_W(12), .DATA_W(32)) u_dut32 (
        .I_HCLK(clk), .I_HRESET(rst), .I_HSEL(hsel), .I_HREADY(hready),
        .I_HADDR(haddr), .I_HTRANS(htrans), .I_HWRITE(hwrite), .I_HSIZE(hsize),
        .I_HWDATA(hwdata), .O_HRDATA(hrdata), .O_HREADYOUT(hreadyout), .O_HRESP(hresp),
        .O_MADDR(maddr), .O_MWDATA(mwdata), .O_MWREN(mwren), .O_MBE(mbe),
        .O_MREN(mren), .I_MRDATA(mrdata)
    );

    ahb_sram_bridge_bwe #(.ADDR_W(12), .DATA_W(64)) u_dut64 (
        .I_HCLK(clk), .I_HRESET(rst), .I_HSEL(w_hsel), .I_HREADY(w_hready),
        .I_HADDR(w_haddr), .I_HTRANS(w_htrans), .I_HWRITE(w_hwrite), .I_HSIZE(w_hsize),
        .I_HWDATA(w_hwdata), .O_HRDATA(w_hrdata), .O_HREADYOUT(w_hreadyout), .O_HRESP(w_hresp),
        .O_MADDR(w_maddr), .O_MWDATA(w_mwdata), .O_MWREN(w_mwren), .O_MBE(w_mbe),
        .O_MREN(w_mren), .I_MRDATA(w_mrdata)
    );

    always @(posedge clk) begin
        if (mwren) begin
            for (int b = 0; b < 4; b++) begin
                if (mbe[b]) mem32[maddr][8*b +: 8] <= mwdata[8*b +: 8];
            end
        end
        if (mren) mrdata <= mem32[maddr];
    end

    always @(posedge clk) begin
        if (w_mwren) begin
            for (int b = 0; b < 8; b++) begin
                if (w_mbe[b]) mem64[w_maddr][8*b +: 8] <= w_mwdata[8*b +: 8];
            end
        end
        if (w_mren) w_mrdata <= mem64[w_maddr];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ap(input logic wr, input logic [11:0] a, input logic [2:0] sz);
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
    endtask

    task automatic idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    task automatic ap64(input logic wr, input logic [11:0] a, input logic [2:0] sz);
        w_hsel   = 1'b1;
        w_htrans = 2'b10;
        w_hwrite = wr;
        w_haddr  = a;
        w_hsize  = sz;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        ap(1'b0, 12'h010, 3'd2);
        hwdata   = '0;
        w_hsel   = 1'b0;
        w_htrans = 2'b00;
        w_hwrite = 1'b0;
        w_haddr  = '0;
        w_hsize  = 3'd0;
        w_hwdata = '0;

        // Reset held with a live NONSEQ read in front of the slave
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hready", 64'(hreadyout), 64'h1);
        chk("rst_hresp",  64'(hresp),     64'h0);
        chk("rst_mwren",  64'(mwren),     64'h0);
        chk("rst_mren",   64'(mren),      64'h0);
        chk("rst_mbe",    64'(mbe),       64'h0);
        step();
        idle();
        rst = 1'b0;
        step();

        // Word write, idle, read back
        ap(1'b1, 12'h010, 3'd2);
        @(negedge clk);
        chk("ww_ap_mwren", 64'(mwren), 64'h0);
        step();
        idle();
        hwdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("ww_mwren",  64'(mwren),     64'h1);
        chk("ww_maddr",  64'(maddr),     64'h004);
        chk("ww_mbe",    64'(mbe),       64'hF);
        chk("ww_hready", 64'(hreadyout), 64'h1);
        step();
        @(negedge clk);
        chk("ww_one_cycle", 64'(mwren), 64'h0);
        step();
        ap(1'b0, 12'h010, 3'd2);
        @(negedge clk);
        chk("rd_mren",  64'(mren),  64'h1);
        chk("rd_maddr", 64'(maddr), 64'h004);
        step();
        idle();
        @(negedge clk);
        chk("rd_hready", 64'(hreadyout), 64'h1);
        chk("rd_data",   64'(hrdata),    64'hDEADBEEF);

        // Byte then halfword, back to back
        step();
        ap(1'b1, 12'h013, 3'd0);
        step();
        ap(1'b1, 12'h012, 3'd1);
        hwdata = 32'hAA000000;
        @(negedge clk);
        chk("bw_mbe",    64'(mbe),       64'h8);
        chk("bw_hready", 64'(hreadyout), 64'h1);
        step();
        idle();
        hwdata = 32'h12340000;
        @(negedge clk);
        chk("hw_mbe",    64'(mbe),       64'hC);
        chk("hw_hready", 64'(hreadyout), 64'h1);
        step();
        ap(1'b0, 12'h010, 3'd2);
        step();
        idle();
        @(negedge clk);
        chk("bhw_data", 64'(hrdata), 64'h1234BEEF);

        // Write then immediate read of the same word: one wait state
        step();
        ap(1'b1, 12'h020, 3'd2);
        step();
        ap(1'b0, 12'h020, 3'd2);
        hwdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("col_hready", 64'(hreadyout), 64'h0);
        chk("col_mwren",  64'(mwren),     64'h1);
        chk("col_mren",   64'(mren),      64'h0);
        step();
        @(negedge clk);
        chk("stl_hready", 64'(hreadyout), 64'h1);
        chk("stl_mwren",  64'(mwren),     64'h0);
        chk("stl_mren",   64'(mren),      64'h1);
        chk("stl_maddr",  64'(maddr),     64'h008);
        step();
        idle();
        @(negedge clk);
        chk("col_data", 64'(hrdata), 64'hCAFEF00D);

        // Misaligned word read -> two-cycle ERROR
        step();
        ap(1'b0, 12'h002, 3'd2);
        @(negedge clk);
        chk("mis_mren", 64'(mren), 64'h0);
        step();
        idle();
        @(negedge clk);
        chk("mis_e1_hready", 64'(hreadyout), 64'h0);
        chk("mis_e1_hresp",  64'(hresp),     64'h1);
        chk("mis_e1_strobe", 64'({mwren, mren}), 64'h0);
        step();
        @(negedge clk);
        chk("mis_e2_hready", 64'(hreadyout), 64'h1);
        chk("mis_e2_hresp",  64'(hresp),     64'h1);
        step();
        @(negedge clk);
        chk("mis_done_hresp", 64'(hresp), 64'h0);

        // Write followed by an oversize (dword) write: no stall, then ERROR
        step();
        ap(1'b1, 12'h030, 3'd2);
        step();
        ap(1'b1, 12'h030, 3'd3);
        hwdata = 32'h11223344;
        @(negedge clk);
        chk("big_nostall", 64'(hreadyout), 64'h1);
        chk("big_prev_wr", 64'(mwren),     64'h1);
        step();
        idle();
        @(negedge clk);
        chk("big_e1_hready", 64'(hreadyout), 64'h0);
        chk("big_e1_hresp",  64'(hresp),     64'h1);
        chk("big_e1_strobe", 64'({mwren, mren}), 64'h0);
        step();
        @(negedge clk);
        chk("big_e2_hready", 64'(hreadyout), 64'h1);
        chk("big_e2_hresp",  64'(hresp),     64'h1);

        // 64-bit build: dword write and readback
        step();
        ap64(1'b1, 12'h018, 3'd3);
        @(negedge clk);
        chk("d64_ap_mwren", 64'(w_mwren), 64'h0);
        step();
        w_hsel   = 1'b0;
        w_htrans = 2'b00;
        w_hwdata = 64'h0123456789ABCDEF;
        @(negedge clk);
        chk("d64_mwren",  64'(w_mwren),     64'h1);
        chk("d64_maddr",  64'(w_maddr),     64'h003);
        chk("d64_mbe",    64'(w_mbe),       64'hFF);
        chk("d64_hready", 64'(w_hreadyout), 64'h1);
        step();
        ap64(1'b0, 12'h018, 3'd3);
        @(negedge clk);
        chk("d64_mren",  64'(w_mren),  64'h1);
        chk("d64_raddr", 64'(w_maddr), 64'h003);
        step();
        w_hsel   = 1'b0;
        w_htrans = 2'b00;
        @(negedge clk);
        chk("d64_data", w_hrdata, 64'h0123456789ABCDEF);

        // Reset asserted during a write data phase kills the strobe at once
        step();
        ap(1'b1, 12'h040, 3'd2);
        step();
        idle();
        hwdata = 32'h55555555;
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_mwren", 64'(mwren), 64'h0);
        chk("rst_mid_mbe",   64'(mbe),   64'h0);
        step();
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
